trap_ctrl: RTL

Trap/interrupt sequencer in front of the machine-mode CSR file. It arbitrates pipeline exception requests, `mret` and enabled interrupts. It stalls and drains the pipeline, then issues one commit strobe to the CSR file (mepc/mcause/mstatus update). Finally it drives a ready/valid redirect to fetch (trap vector or mepc).

---
 rtl/trap_pkg.sv | 35 +++
 rtl/trap_prio_enc.sv | 46 ++++
 rtl/trap_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_MRET = 2'd1,
        KIND_IRQ  = 2'd2
    } kind_e;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic        is_irq,
                                                input logic [4:0]  cause);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == MTVEC_VECTORED && is_irq)
            return base + {25'b0, cause, 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority pick of the winning exception (lowest index) and interrupt (ext > sw > timer).
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int NUM_EXC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_EXC-1:0]   exc_req,
    input  logic [NUM_EXC*5-1:0] exc_cause,
    input  logic [2:0]           irq_pend,
    output logic                 exc_valid,
    output logic [IDX_W-1:0]     exc_idx,
    output logic [4:0]           exc_sel_cause,
    output logic                 irq_valid,
    output logic [4:0]           irq_sel_cause
);

    // Descending scan so the lowest active index is the last one written.
    always_comb begin
        exc_valid     = 1'b0;
        exc_idx       = '0;
        exc_sel_cause = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_req[i]) begin
                exc_valid     = 1'b1;
                exc_idx       = IDX_W'(i);
                exc_sel_cause = exc_cause[i*5 +: 5];
            end
        end
    end

    // irq_pend is ordered {ext, timer, sw}.
    always_comb begin
        irq_valid     = 1'b1;
        irq_sel_cause = '0;
        if (irq_pend[2])
            irq_sel_cause = CAUSE_MEI;
        else if (irq_pend[0])
            irq_sel_cause = CAUSE_MSI;
        else if (irq_pend[1])
            irq_sel_cause = CAUSE_MTI;
        else
            irq_valid = 1'b0;
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: selects a request, drains the pipeline, commits to the CSRs, redirects fetch.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int NUM_EXC       = 4,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_EXC-1:0]   exc_req,
    input  logic [NUM_EXC*5-1:0] exc_cause,
    input  logic [NUM_EXC*32-1:0] exc_pc,
    output logic [NUM_EXC-1:0]   exc_ack,
    input  logic                 irq_ext,
    input  logic                 irq_timer,
    input  logic                 irq_sw,
    input  logic                 mstatus_mie,
    input  logic [2:0]           mie_en,
    input  logic [31:0]          current_pc,
    input  logic                 mret_req,
    output logic                 mret_ack,
    input  logic [31:0]          mtvec,
    input  logic [31:0]          mepc,
    input  logic                 pipe_empty,
    output logic                 stall,
    output logic                 flush,
    output logic                 trap_valid,
    output logic [31:0]          trap_pc,
    output logic [31:0]          trap_cause,
    output logic                 mret_valid,
    output logic                 redirect_valid,
    input  logic                 redirect_ready,
    output logic [31:0]          redirect_pc,
    output logic                 drain_timeout,
    output logic                 busy
);

    localparam int IDX_W = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
    localparam logic [3:0] CNT_LAST = 4'(DRAIN_TIMEOUT - 1);

    state_e             state_q, state_d;
    kind_e              kind_q, kind_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4:0]         cause_q, cause_d;
    logic [31:0]        pc_q, pc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rpc_q, rpc_d;
    logic               timeout_q, timeout_d;

    logic               exc_valid, irq_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [4:0]         sel_exc_cause, sel_irq_cause;
    logic [31:0]        sel_pc;
    logic [2:0]         irq_pend;

    assign irq_pend = {irq_ext & mie_en[2], irq_timer & mie_en[1], irq_sw & mie_en[0]}
                      & {3{mstatus_mie}};

    trap_prio_enc #(
        .NUM_EXC (NUM_EXC),
        .IDX_W   (IDX_W)
    ) u_prio (
        .exc_req       (exc_req),
        .exc_cause     (exc_cause),
        .irq_pend      (irq_pend),
        .exc_valid     (exc_valid),
        .exc_idx       (sel_idx),
        .exc_sel_cause (sel_exc_cause),
        .irq_valid     (irq_valid),
        .irq_sel_cause (sel_irq_cause)
    );

    always_comb begin
        sel_pc = '0;
        for (int i = 0; i < NUM_EXC; i++) begin
            if (sel_idx == IDX_W'(i))
                sel_pc = exc_pc[i*32 +: 32];
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        idx_d     = idx_q;
        cause_d   = cause_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        rpc_d     = rpc_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (exc_valid) begin
                    kind_d  = KIND_EXC;
                    idx_d   = sel_idx;
                    cause_d = sel_exc_cause;
                    pc_d    = sel_pc;
                    state_d = ST_DRAIN;
                end else if (mret_req) begin
                    kind_d  = KIND_MRET;
                    idx_d   = '0;
                    cause_d = '0;
                    pc_d    = '0;
                    state_d = ST_DRAIN;
                end else if (irq_valid) begin
                    kind_d  = KIND_IRQ;
                    idx_d   = '0;
                    cause_d = sel_irq_cause;
                    pc_d    = current_pc;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 4'd1;
                if (pipe_empty) begin
                    state_d = ST_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_COMMIT;
                    timeout_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                // CSR values are captured here so the redirect target cannot move mid-handshake.
                if (kind_q == KIND_MRET)
                    rpc_d = mepc;
                else
                    rpc_d = trap_target(mtvec, kind_q == KIND_IRQ, cause_q);
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_EXC;
            idx_q     <= '0;
            cause_q   <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            rpc_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            idx_q     <= idx_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            rpc_q     <= rpc_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decode only from state and latches, so an async reset clears them at once.
    logic first_drain;
    assign first_drain    = (state_q == ST_DRAIN) && (cnt_q == 4'd0);
    assign exc_ack        = (first_drain && kind_q == KIND_EXC) ? (NUM_EXC'(1) << idx_q) : '0;
    assign mret_ack       = first_drain && (kind_q == KIND_MRET);
    assign stall          = (state_q != ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign flush          = (state_q == ST_COMMIT);
    assign trap_valid     = (state_q == ST_COMMIT) && (kind_q != KIND_MRET);
    assign mret_valid     = (state_q == ST_COMMIT) && (kind_q == KIND_MRET);
    assign trap_pc        = trap_valid ? pc_q : '0;
    assign trap_cause     = trap_valid ? {kind_q == KIND_IRQ, 26'b0, cause_q} : '0;
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = redirect_valid ? rpc_q : '0;
    assign drain_timeout  = timeout_q;

endmodule
